// File: rtl/fm7_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fm7_bus_pkg : shared phase encoding and bus decode constants         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package fm7_bus_pkg;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_e;

  localparam logic [15:0] FD0F_ADDR   = 16'hFD0F;
  localparam logic        STROBE_IDLE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bus_phase_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_phase_div : quarter-phase divider producing E/Q and E-fall enable|
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module bus_phase_div
  import fm7_bus_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic   clk,
  input  logic   rst,
  output phase_e ph,
  output phase_e ph_next,
  output logic   e,
  output logic   q,
  output logic   e_fall_ce
);

  localparam int QW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(DIV - 1);

  logic [QW-1:0] qcnt;
  logic [QW-1:0] qcnt_next;
  logic          qend;

  always_comb begin
    qend      = (qcnt == QLAST);
    qcnt_next = qend ? '0 : qcnt + 1'b1;
    ph_next   = qend ? phase_e'(ph + 2'd1) : ph;
  end

  // E/Q/E_FALL_CE are decoded from the next state so they line up with ph
  always_ff @(posedge clk) begin
    if (rst) begin
      qcnt      <= '0;
      ph        <= PH0;
      e         <= 1'b0;
      q         <= 1'b0;
      e_fall_ce <= 1'b0;
    end else begin
      qcnt      <= qcnt_next;
      ph        <= ph_next;
      e         <= (ph_next == PH2) || (ph_next == PH3);
      q         <= (ph_next == PH1) || (ph_next == PH2);
      e_fall_ce <= (ph_next == PH3) && (qcnt_next == QLAST);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mainbus_cycle_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mainbus_cycle_gen : main-CPU bus cycle sequencer, $FD0F strobes and  |
// |                     stretched system reset                           |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module mainbus_cycle_gen
  import fm7_bus_pkg::*;
#(
  parameter int DIV         = 4,
  parameter int RST_STRETCH = 8
) (
  input  logic        CLKSYS,
  input  logic        RST,
  input  logic [15:0] CPU_ADDR,
  input  logic        CPU_RW,
  output logic        E,
  output logic        Q,
  output logic        E_FALL_CE,
  output logic [15:0] MADDRBUS,
  output logic        MRW,
  output logic        RDQEn,
  output logic        RFD0Fn,
  output logic        WFD0Fn,
  output logic        RESETBn
);

  localparam int SW = $clog2(RST_STRETCH + 1);

  phase_e        ph;
  phase_e        ph_next;
  logic [SW-1:0] stretch;
  logic [SW-1:0] stretch_next;
  logic [15:0]   addr_next;
  logic          rw_next;
  logic          rb_next;
  logic          hit_next;
  logic          rdq_next;
  logic          rfd_next;
  logic          wfd_next;

  bus_phase_div #(
    .DIV (DIV)
  ) u_phase_div (
    .clk       (CLKSYS),
    .rst       (RST),
    .ph        (ph),
    .ph_next   (ph_next),
    .e         (E),
    .q         (Q),
    .e_fall_ce (E_FALL_CE)
  );

  // Strobes are built from next-state values so they switch on the same
  // edge as the phase, including the ph1 entry where the address is latched.
  always_comb begin
    stretch_next = stretch;
    addr_next    = MADDRBUS;
    rw_next      = MRW;
    if (E_FALL_CE && (stretch != '0)) begin
      stretch_next = stretch - 1'b1;
    end
    if ((ph == PH0) && (ph_next == PH1)) begin
      addr_next = CPU_ADDR;
      rw_next   = CPU_RW;
    end
    rb_next  = (stretch_next == '0);
    hit_next = (addr_next == FD0F_ADDR);
    rdq_next = ~((ph_next != PH0) && rw_next && rb_next);
    rfd_next = ~(((ph_next == PH2) || (ph_next == PH3)) && hit_next && rw_next && rb_next);
    wfd_next = ~((ph_next == PH3) && hit_next && !rw_next && rb_next);
  end

  always_ff @(posedge CLKSYS) begin
    if (RST) begin
      stretch  <= SW'(RST_STRETCH);
      MADDRBUS <= 16'h0000;
      MRW      <= 1'b1;
      RDQEn    <= STROBE_IDLE;
      RFD0Fn   <= STROBE_IDLE;
      WFD0Fn   <= STROBE_IDLE;
      RESETBn  <= 1'b0;
    end else begin
      stretch  <= stretch_next;
      MADDRBUS <= addr_next;
      MRW      <= rw_next;
      RDQEn    <= rdq_next;
      RFD0Fn   <= rfd_next;
      WFD0Fn   <= wfd_next;
      RESETBn  <= rb_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mainbus_cycle_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mainbus_cycle_gen : randomized bench against a time-index model   |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module tb_mainbus_cycle_gen;

  localparam int DIV         = 4;
  localparam int RST_STRETCH = 8;
  localparam int CYC         = 4 * DIV;

  logic        CLKSYS = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] CPU_ADDR = 16'h0000;
  logic        CPU_RW = 1'b1;
  logic        E, Q, E_FALL_CE, MRW, RDQEn, RFD0Fn, WFD0Fn, RESETBn;
  logic [15:0] MADDRBUS;

  int checks = 0;
  int errors = 0;

  // model: clocks since last reset edge, plus the captured bus address
  int          t = 0;
  logic [15:0] m_addr = 16'h0000;
  logic        m_rw = 1'b1;

  mainbus_cycle_gen #(
    .DIV         (DIV),
    .RST_STRETCH (RST_STRETCH)
  ) dut (
    .CLKSYS    (CLKSYS),
    .RST       (RST),
    .CPU_ADDR  (CPU_ADDR),
    .CPU_RW    (CPU_RW),
    .E         (E),
    .Q         (Q),
    .E_FALL_CE (E_FALL_CE),
    .MADDRBUS  (MADDRBUS),
    .MRW       (MRW),
    .RDQEn     (RDQEn),
    .RFD0Fn    (RFD0Fn),
    .WFD0Fn    (WFD0Fn),
    .RESETBn   (RESETBn)
  );

  always #5 CLKSYS = ~CLKSYS;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %h, expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic step(input logic rst_in, input logic [15:0] addr, input logic rw);
    int   qc, p;
    logic rb, hit;
    RST      = rst_in;
    CPU_ADDR = addr;
    CPU_RW   = rw;
    @(posedge CLKSYS);
    if (rst_in) begin
      t      = 0;
      m_addr = 16'h0000;
      m_rw   = 1'b1;
    end else begin
      t = t + 1;
      if ((t % CYC) == DIV) begin
        m_addr = addr;
        m_rw   = rw;
      end
    end
    #1;
    qc  = t % DIV;
    p   = (t / DIV) % 4;
    rb  = (t >= RST_STRETCH * CYC);
    hit = (m_addr == 16'hFD0F);
    check_val("E",         {15'd0, E},         {15'd0, p >= 2});
    check_val("Q",         {15'd0, Q},         {15'd0, (p == 1) || (p == 2)});
    check_val("E_FALL_CE", {15'd0, E_FALL_CE}, {15'd0, (p == 3) && (qc == DIV - 1)});
    check_val("MADDRBUS",  MADDRBUS,           m_addr);
    check_val("MRW",       {15'd0, MRW},       {15'd0, m_rw});
    check_val("RESETBn",   {15'd0, RESETBn},   {15'd0, rb});
    check_val("RDQEn",     {15'd0, RDQEn},     {15'd0, !((p != 0) && m_rw && rb)});
    check_val("RFD0Fn",    {15'd0, RFD0Fn},    {15'd0, !((p >= 2) && hit && m_rw && rb)});
    check_val("WFD0Fn",    {15'd0, WFD0Fn},    {15'd0, !((p == 3) && hit && !m_rw && rb)});
    check_val("excl",      {15'd0, RFD0Fn | WFD0Fn}, 16'd1);
  endtask

  initial begin
    int          low_run;
    logic [15:0] a;
    logic        rst_r;
    // power-on reset, then masked FD0F reads during the stretch
    repeat (3) step(1'b1, 16'hFD0F, 1'b1);
    low_run = 0;
    for (int i = 0; i < RST_STRETCH * CYC; i++) begin
      step(1'b0, 16'hFD0F, 1'b1);
      if (!RESETBn) low_run++;
    end
    check_val("stretch_len", 16'(low_run), 16'(RST_STRETCH * CYC - 1));
    // directed cycles: read FD0F, write FD0F, read FD0E
    repeat (CYC) step(1'b0, 16'hFD0F, 1'b1);
    repeat (CYC) step(1'b0, 16'hFD0F, 1'b0);
    repeat (CYC) step(1'b0, 16'hFD0E, 1'b1);
    // reset during ph2 of an FD0F read
    repeat (2 * DIV + 1) step(1'b0, 16'hFD0F, 1'b1);
    check_val("pre_rst_rfd", {15'd0, RFD0Fn}, 16'd0);
    step(1'b1, 16'hFD0F, 1'b1);
    step(1'b1, 16'hFD0F, 1'b1);
    // randomized traffic with occasional resets
    for (int i = 0; i < 6000; i++) begin
      a     = ($urandom_range(0, 1) == 0) ? (16'hFD0E + 16'($urandom_range(0, 1))) : 16'($urandom);
      rst_r = ($urandom_range(0, 999) < 2);
      step(rst_r, a, 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
